// File: rtl/bf_io_buffer_pkg.sv
// Shared constants and helpers for the bf cpu I/O bridge.
package bf_io_buffer_pkg;

   localparam int GEN_MODE_HOST  = 0;
   localparam int GEN_MODE_COUNT = 1;

   // Occupancy counters need one bit more than the address so DEPTH itself fits.
   function automatic int count_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/bf_sync_fifo.sv
// First-word-fall-through synchronous FIFO with wrap-bit pointers and a registered occupancy count.
module bf_sync_fifo
   import bf_io_buffer_pkg::*;
#(
   parameter int WIDTH               = 8,
   parameter int DEPTH               = 16,
   parameter bit ALLOW_FULL_PUSH_POP = 1'b0
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          push,
   input  logic [WIDTH-1:0]              push_data,
   input  logic                          pop,
   output logic [WIDTH-1:0]              head,
   output logic                          full,
   output logic                          empty,
   output logic [count_width(DEPTH)-1:0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] ONE = (AW + 1)'(1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

   // The head is forced to zero when empty so unwritten storage never leaks onto the ports.
   assign head    = empty ? '0 : mem[rd_ptr[AW-1:0]];
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | (ALLOW_FULL_PUSH_POP & do_pop));

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr[AW-1:0]] <= push_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + ONE;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + ONE;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + ONE;
            2'b01:   count <= count - ONE;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/bf_io_buffer.sv
// Bridges the bf cpu byte ports to host valid/ready streams, with an optional counter source.
module bf_io_buffer
   import bf_io_buffer_pkg::*;
#(
   parameter int DATA_WIDTH  = 8,
   parameter int IN_DEPTH    = 16,
   parameter int OUT_DEPTH   = 16,
   parameter int GEN_MODE    = GEN_MODE_HOST,
   parameter int GEN_START   = 0,
   parameter int START_DELAY = 5
) (
   input  logic                              clk,
   input  logic                              rst,
   output logic [DATA_WIDTH-1:0]             cpu_data_in,
   output logic                              cpu_data_available,
   input  logic                              cpu_data_read,
   input  logic [DATA_WIDTH-1:0]             cpu_data_out,
   input  logic                              cpu_data_out_en,
   input  logic [DATA_WIDTH-1:0]             host_in_data,
   input  logic                              host_in_valid,
   output logic                              host_in_ready,
   output logic [DATA_WIDTH-1:0]             host_out_data,
   output logic                              host_out_valid,
   input  logic                              host_out_ready,
   output logic [count_width(IN_DEPTH)-1:0]  in_count,
   output logic [count_width(OUT_DEPTH)-1:0] out_count,
   output logic                              overflow,
   input  logic                              overflow_clr
);

   logic out_full;
   logic out_empty;
   logic out_drop;

   if (GEN_MODE == GEN_MODE_HOST) begin : g_host_src
      logic in_full;
      logic in_empty;

      bf_sync_fifo #(
         .WIDTH               (DATA_WIDTH),
         .DEPTH               (IN_DEPTH),
         .ALLOW_FULL_PUSH_POP (1'b0)
      ) u_in_fifo (
         .clk       (clk),
         .rst       (rst),
         .push      (host_in_valid),
         .push_data (host_in_data),
         .pop       (cpu_data_read),
         .head      (cpu_data_in),
         .full      (in_full),
         .empty     (in_empty),
         .count     (in_count)
      );

      assign cpu_data_available = ~in_empty;
      assign host_in_ready      = ~in_full;
   end else begin : g_count_src
      logic [DATA_WIDTH-1:0] gen_value;
      logic [7:0]            delay_left;
      logic                  unused_host_in;

      assign unused_host_in = ^{host_in_data, host_in_valid};

      // Availability latches high once the start delay has run out and never drops again.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            gen_value  <= DATA_WIDTH'(GEN_START);
            delay_left <= 8'(START_DELAY);
         end else begin
            if (delay_left != 8'd0) begin
               delay_left <= delay_left - 8'd1;
            end
            if (cpu_data_read && (delay_left == 8'd0)) begin
               gen_value <= gen_value + DATA_WIDTH'(1);
            end
         end
      end

      assign cpu_data_in        = gen_value;
      assign cpu_data_available = (delay_left == 8'd0);
      assign host_in_ready      = 1'b0;
      assign in_count           = '0;
   end

   bf_sync_fifo #(
      .WIDTH               (DATA_WIDTH),
      .DEPTH               (OUT_DEPTH),
      .ALLOW_FULL_PUSH_POP (1'b1)
   ) u_out_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (cpu_data_out_en),
      .push_data (cpu_data_out),
      .pop       (host_out_ready),
      .head      (host_out_data),
      .full      (out_full),
      .empty     (out_empty),
      .count     (out_count)
   );

   assign host_out_valid = ~out_empty;

   // The cpu cannot be stalled, so a write into a full FIFO with no same-edge pop is lost.
   assign out_drop = cpu_data_out_en & out_full & ~host_out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow <= 1'b0;
      end else if (out_drop) begin
         overflow <= 1'b1;
      end else if (overflow_clr) begin
         overflow <= 1'b0;
      end
   end

endmodule
